// File: rtl/gpio_cfg_pkg.sv
// Shared constants and types for the GPIO configuration loader:
// field positions of the configuration word, FSM states and the reset default.
package gpio_cfg_pkg;

    localparam int CFG_MGMT_ENA    = 0;
    localparam int CFG_OUTENB      = 1;
    localparam int CFG_HOLDOVER    = 2;
    localparam int CFG_INP_DIS     = 3;
    localparam int CFG_IB_MODE_SEL = 4;
    localparam int CFG_ANALOG_EN   = 5;
    localparam int CFG_ANALOG_SEL  = 6;
    localparam int CFG_ANALOG_POL  = 7;
    localparam int CFG_SLOW_SEL    = 8;
    localparam int CFG_VTRIP_SEL   = 9;
    localparam int CFG_DM_LSB      = 10;
    localparam int CFG_DM_MSB      = 12;

    localparam logic [12:0] CFG_RESET_DEFAULT = 13'h0402;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2
    } cfg_state_t;

    function automatic logic [2:0] cfg_dm(input logic [12:0] cfg);
        return cfg[CFG_DM_MSB:CFG_DM_LSB];
    endfunction

endpackage

// File: rtl/gpio_cfg_shreg.sv
// Serial configuration shift register with a saturating count of bits
// shifted since the last parallel load or counter clear.
module gpio_cfg_shreg
    import gpio_cfg_pkg::*;
#(
    parameter int CFG_W           = 13,
    parameter int SHIFT_MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CFG_W-1:0] load_val,
    input  logic             shift,
    input  logic             din,
    input  logic             clr_cnt,
    output logic [CFG_W-1:0] shreg,
    output logic [3:0]       bit_count
);

    localparam logic [3:0] CNT_MAX = 4'(CFG_W);

    logic [CFG_W-1:0] shreg_q, shreg_d, shifted;
    logic [3:0]       cnt_q, cnt_d;

    always_comb begin
        if (SHIFT_MSB_FIRST != 0) shifted = {shreg_q[CFG_W-2:0], din};
        else                      shifted = {din, shreg_q[CFG_W-1:1]};

        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = load_val;
            cnt_d   = 4'd0;
        end else begin
            if (shift) shreg_d = shifted;
            // A commit clears the count even if a bit shifts in the same cycle.
            if (clr_cnt)                      cnt_d = 4'd0;
            else if (shift && cnt_q != CNT_MAX) cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg_q <= '0;
            cnt_q   <= 4'd0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign shreg     = shreg_q;
    assign bit_count = cnt_q;

endmodule

// File: rtl/gpio_config_loader.sv
// GPIO pad configuration loader: captures mask defaults after reset, accepts
// serially shifted words on commit, and flags value changes with a pulse.
module gpio_config_loader
    import gpio_cfg_pkg::*;
#(
    parameter int CFG_W           = 13,
    parameter int SHIFT_MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [CFG_W-1:0] gpio_defaults,
    input  logic             load_defaults,
    input  logic             serial_en,
    input  logic             serial_data_in,
    input  logic             serial_load,
    output logic             serial_data_out,
    output logic [CFG_W-1:0] gpio_config,
    output logic             cfg_valid,
    output logic             cfg_changed,
    output logic [3:0]       bit_count
);

    cfg_state_t       state_q, state_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;
    logic             sh_load, sh_shift, sh_clr;
    logic [CFG_W-1:0] shreg;

    gpio_cfg_shreg #(
        .CFG_W          (CFG_W),
        .SHIFT_MSB_FIRST(SHIFT_MSB_FIRST)
    ) u_shreg (
        .clk      (clk),
        .resetn   (resetn),
        .load     (sh_load),
        .load_val (gpio_defaults),
        .shift    (sh_shift),
        .din      (serial_data_in),
        .clr_cnt  (sh_clr),
        .shreg    (shreg),
        .bit_count(bit_count)
    );

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_clr    = 1'b0;
        case (state_q)
            INIT: begin
                cfg_d   = gpio_defaults;
                valid_d = 1'b1;
                sh_load = 1'b1;
                state_d = IDLE;
            end
            IDLE, SHIFT: begin
                state_d = serial_en ? SHIFT : IDLE;
                if (load_defaults) begin
                    cfg_d   = gpio_defaults;
                    sh_load = 1'b1;
                end else begin
                    sh_shift = serial_en;
                    if (serial_load) begin
                        cfg_d  = shreg;
                        sh_clr = 1'b1;
                    end
                end
                changed_d = (cfg_d != cfg_q);
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= INIT;
            cfg_q     <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign serial_data_out = shreg[CFG_W-1];
    assign gpio_config     = cfg_q;
    assign cfg_valid       = valid_q;
    assign cfg_changed     = changed_q;

endmodule

// File: tb/tb_gpio_config_loader.sv
// Directed bench for gpio_config_loader: reset capture, shift/commit,
// pass-through, priority, mid-shift reset, change detection and saturation.
module tb_gpio_config_loader;

    logic        clk = 1'b0;
    logic        resetn;
    logic [12:0] gpio_defaults;
    logic        load_defaults, serial_en, serial_data_in, serial_load;
    logic        serial_data_out;
    logic [12:0] gpio_config;
    logic        cfg_valid, cfg_changed;
    logic [3:0]  bit_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_config_loader dut (
        .clk            (clk),
        .resetn         (resetn),
        .gpio_defaults  (gpio_defaults),
        .load_defaults  (load_defaults),
        .serial_en      (serial_en),
        .serial_data_in (serial_data_in),
        .serial_load    (serial_load),
        .serial_data_out(serial_data_out),
        .gpio_config    (gpio_config),
        .cfg_valid      (cfg_valid),
        .cfg_changed    (cfg_changed),
        .bit_count      (bit_count)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input logic [12:0] cfg, input logic valid,
                                 input logic chg, input logic [3:0] cnt);
        check({tag, ".cfg"},     16'(gpio_config), 16'(cfg));
        check({tag, ".valid"},   16'(cfg_valid),   16'(valid));
        check({tag, ".changed"}, 16'(cfg_changed), 16'(chg));
        check({tag, ".count"},   16'(bit_count),   16'(cnt));
    endtask

    initial begin
        logic [12:0] dflt;
        logic [12:0] word;
        dflt = 13'h0402;
        word = 13'h1803;

        resetn         = 1'b0;
        gpio_defaults  = dflt;
        load_defaults  = 1'b0;
        serial_en      = 1'b0;
        serial_data_in = 1'b0;
        serial_load    = 1'b0;
        tick();
        tick();
        check_outputs("reset", 13'h0000, 1'b0, 1'b0, 4'd0);
        check("reset.sdo", 16'(serial_data_out), 16'd0);

        resetn = 1'b1;
        tick();
        check_outputs("init", 13'h0402, 1'b1, 1'b0, 4'd0);
        tick();
        check_outputs("init_hold", 13'h0402, 1'b1, 1'b0, 4'd0);

        // Shift in 0x1803 MSB-first while the defaults replay out.
        for (int i = 0; i < 13; i++) begin
            serial_en      = 1'b1;
            serial_data_in = word[12-i];
            #1;
            check($sformatf("passthru[%0d]", i), 16'(serial_data_out), 16'(dflt[12-i]));
            tick();
            check($sformatf("noalter[%0d]", i), 16'(gpio_config), 16'h0402);
        end
        serial_en = 1'b0;
        #1;
        check_outputs("shifted", 13'h0402, 1'b1, 1'b0, 4'd13);
        check("shifted.sdo", 16'(serial_data_out), 16'd1);

        serial_load = 1'b1;
        tick();
        serial_load = 1'b0;
        check_outputs("commit", 13'h1803, 1'b1, 1'b1, 4'd0);
        tick();
        check_outputs("commit_after", 13'h1803, 1'b1, 1'b0, 4'd0);

        // Identical recommit: shift register still holds 0x1803.
        serial_load = 1'b1;
        tick();
        serial_load = 1'b0;
        check_outputs("same_commit", 13'h1803, 1'b1, 1'b0, 4'd0);

        serial_en      = 1'b1;
        serial_data_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 11) check("count12", 16'(bit_count), 16'd12);
        end
        serial_en = 1'b0;
        check("saturate", 16'(bit_count), 16'd13);
        check("sat_cfg", 16'(gpio_config), 16'h1803);

        // Shift register now 0x1FFF; load_defaults must win over everything.
        load_defaults  = 1'b1;
        serial_load    = 1'b1;
        serial_en      = 1'b1;
        serial_data_in = 1'b1;
        tick();
        load_defaults = 1'b0;
        serial_load   = 1'b0;
        serial_en     = 1'b0;
        check_outputs("prio", 13'h0402, 1'b1, 1'b1, 4'd0);
        check("prio.sdo", 16'(serial_data_out), 16'd0);
        serial_load = 1'b1;
        tick();
        serial_load = 1'b0;
        check_outputs("prio_shreg", 13'h0402, 1'b1, 1'b0, 4'd0);

        gpio_defaults = 13'h0AAA;
        load_defaults = 1'b1;
        tick();
        load_defaults = 1'b0;
        check_outputs("reload_new", 13'h0AAA, 1'b1, 1'b1, 4'd0);
        load_defaults = 1'b1;
        tick();
        load_defaults = 1'b0;
        check_outputs("reload_same", 13'h0AAA, 1'b1, 1'b0, 4'd0);
        gpio_defaults = dflt;

        serial_en      = 1'b1;
        serial_data_in = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("mid.count", 16'(bit_count), 16'd6);
        resetn = 1'b0;
        #1;
        check_outputs("mid_reset", 13'h0000, 1'b0, 1'b0, 4'd0);
        check("mid_reset.sdo", 16'(serial_data_out), 16'd0);
        serial_en = 1'b0;
        tick();
        check_outputs("mid_reset_hold", 13'h0000, 1'b0, 1'b0, 4'd0);
        resetn = 1'b1;
        tick();
        check_outputs("reinit", 13'h0402, 1'b1, 1'b0, 4'd0);
        serial_load = 1'b1;
        tick();
        serial_load = 1'b0;
        check_outputs("reinit_commit", 13'h0402, 1'b1, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
